// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_if : AXI4-Stream byte channel carrying received UART words         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx : 8N1-style UART receiver with AXI4-Stream output, 8x prescale     |
// | Optional macro UART_RX_GLITCH_FILTER_EN adds a 3-tap majority filter.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  wire             clk,
  input  wire             rst_n,
  uart_rx_if.master       output_axis,
  input  wire             rxd,
  output logic            busy,
  output logic            overrun_error,
  output logic            frame_error,
  input  wire  [15:0]     prescale
);

  localparam int c_BCW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic r_rxd_meta;
  logic r_rxd_sync;
  logic w_rxd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] r_rxd_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_hist <= 2'b11;
    end else begin
      r_rxd_hist <= {r_rxd_hist[0], r_rxd_sync};
    end
  end

  // Two of three taps must agree, so a single-clock spike never propagates.
  assign w_rxd_s = (r_rxd_sync & r_rxd_hist[0]) |
                   (r_rxd_sync & r_rxd_hist[1]) |
                   (r_rxd_hist[0] & r_rxd_hist[1]);
`else
  assign w_rxd_s = r_rxd_sync;
`endif

  state_t                r_state,   w_state_nxt;
  logic [18:0]           r_cnt,     w_cnt_nxt;
  logic [c_BCW-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [15:0]           r_p,       w_p_nxt;
  logic [DATA_WIDTH-1:0] r_shift,   w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_tdata,   w_tdata_nxt;
  logic                  r_tvalid,  w_tvalid_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  r_ovr,     w_ovr_nxt;
  logic                  r_ferr,    w_ferr_nxt;
  logic                  w_cnt_zero;
  logic [18:0]           w_bit_reload;

  assign w_cnt_zero   = (r_cnt == 19'd0);
  assign w_bit_reload = {r_p, 3'b000} - 19'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_p       <= '0;
      r_shift   <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_p       <= w_p_nxt;
      r_shift   <= w_shift_nxt;
      r_tdata   <= w_tdata_nxt;
      r_tvalid  <= w_tvalid_nxt;
      r_busy    <= w_busy_nxt;
      r_ovr     <= w_ovr_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_p_nxt       = r_p;
    w_shift_nxt   = r_shift;
    w_tdata_nxt   = r_tdata;
    w_tvalid_nxt  = r_tvalid & ~output_axis.tready;
    w_busy_nxt    = r_busy;
    w_ovr_nxt     = 1'b0;
    w_ferr_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if ((prescale != 16'd0) && !w_rxd_s) begin
          w_p_nxt     = prescale;
          w_cnt_nxt   = {1'b0, prescale, 2'b00} - 19'd1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_cnt_zero) begin
          if (!w_rxd_s) begin
            w_cnt_nxt     = w_bit_reload;
            w_bit_cnt_nxt = c_BCW'(DATA_WIDTH);
            w_state_nxt   = S_DATA;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 19'd1;
        end
      end
      S_DATA: begin
        if (w_cnt_zero) begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          w_shift_nxt   = {w_rxd_s, r_shift[DATA_WIDTH-1:1]};
          w_cnt_nxt     = w_bit_reload;
          w_bit_cnt_nxt = r_bit_cnt - c_BCW'(1);
          if (r_bit_cnt == c_BCW'(1)) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 19'd1;
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          if (w_rxd_s) begin
            w_tdata_nxt  = r_shift;
            w_tvalid_nxt = 1'b1;
            w_ovr_nxt    = r_tvalid & ~output_axis.tready;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - 19'd1;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so a break reports only one error.
        if (w_rxd_s) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign output_axis.tdata  = r_tdata;
  assign output_axis.tvalid = r_tvalid;
  assign busy               = r_busy;
  assign overrun_error      = r_ovr;
  assign frame_error        = r_ferr;

endmodule
`default_nettype wire
